// File: rtl/sa_feeder.sv
// sa_feeder: input sequencer for an NxN systolic matrix multiplier.
// Holds one A and one B matrix, loaded through a write port while idle.
// On start it clears the array accumulators, streams diagonally skewed
// A rows (west edge) and B columns (north edge), zero-flushes the array,
// then pulses done.
// Ports:
//   clk, rst                   clock, async active-high reset
//   wr_en/wr_sel/wr_row/wr_col/wr_data  matrix storage write (IDLE only)
//   start                      begin one multiply (sampled in IDLE)
//   busy, done, sa_clr         status / accumulator clear (registered)
//   A0..A7, B0..B7             west / north edge wavefronts (registered)
module sa_feeder #(
    parameter int unsigned N     = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   wr_sel,
    input  logic [$clog2(N)-1:0]   wr_row,
    input  logic [$clog2(N)-1:0]   wr_col,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   sa_clr,
    output logic [WIDTH-1:0]       A0,
    output logic [WIDTH-1:0]       A1,
    output logic [WIDTH-1:0]       A2,
    output logic [WIDTH-1:0]       A3,
    output logic [WIDTH-1:0]       A4,
    output logic [WIDTH-1:0]       A5,
    output logic [WIDTH-1:0]       A6,
    output logic [WIDTH-1:0]       A7,
    output logic [WIDTH-1:0]       B0,
    output logic [WIDTH-1:0]       B1,
    output logic [WIDTH-1:0]       B2,
    output logic [WIDTH-1:0]       B3,
    output logic [WIDTH-1:0]       B4,
    output logic [WIDTH-1:0]       B5,
    output logic [WIDTH-1:0]       B6,
    output logic [WIDTH-1:0]       B7
);

    localparam int unsigned IDX_W       = $clog2(N);
    localparam int unsigned STEP_W      = $clog2(2 * N);
    localparam int unsigned STREAM_LAST = 2 * N - 2;
    localparam int unsigned DRAIN_LAST  = N - 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [STEP_W-1:0]   step, step_nxt;
    logic [WIDTH-1:0]    a_mem [N][N];
    logic [WIDTH-1:0]    b_mem [N][N];
    logic [WIDTH-1:0]    a_edge [N];
    logic [WIDTH-1:0]    b_edge [N];
    logic [WIDTH-1:0]    a_edge_nxt [N];
    logic [WIDTH-1:0]    b_edge_nxt [N];
    logic                busy_nxt, done_nxt, sa_clr_nxt;

    // Matrix storage: writable only while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_mem[r][c] <= '0;
                    b_mem[r][c] <= '0;
                end
            end
        end else if (wr_en && state == ST_IDLE) begin
            if (!wr_sel) begin
                a_mem[wr_row][wr_col] <= wr_data;
            end else begin
                b_mem[wr_row][wr_col] <= wr_data;
            end
        end
    end

    // State, step counter and all outputs are registered together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            step   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sa_clr <= 1'b0;
            for (int i = 0; i < N; i++) begin
                a_edge[i] <= '0;
                b_edge[i] <= '0;
            end
        end else begin
            state  <= state_nxt;
            step   <= step_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
            sa_clr <= sa_clr_nxt;
            for (int i = 0; i < N; i++) begin
                a_edge[i] <= a_edge_nxt[i];
                b_edge[i] <= b_edge_nxt[i];
            end
        end
    end

    // Next state, and the output values for the cycle that state occupies.
    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_CLEAR;
                    step_nxt  = '0;
                end
            end
            ST_CLEAR: begin
                state_nxt = ST_STREAM;
                step_nxt  = '0;
            end
            ST_STREAM: begin
                if (step == STEP_W'(STREAM_LAST)) begin
                    state_nxt = ST_DRAIN;
                    step_nxt  = '0;
                end else begin
                    step_nxt = step + STEP_W'(1);
                end
            end
            ST_DRAIN: begin
                if (step == STEP_W'(DRAIN_LAST)) begin
                    state_nxt = ST_DONE;
                    step_nxt  = '0;
                end else begin
                    step_nxt = step + STEP_W'(1);
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                step_nxt  = '0;
            end
            default: begin
                state_nxt = ST_IDLE;
                step_nxt  = '0;
            end
        endcase

        busy_nxt   = (state_nxt != ST_IDLE);
        done_nxt   = (state_nxt == ST_DONE);
        sa_clr_nxt = (state_nxt == ST_CLEAR);

        // Lane i carries element k = t - i while 0 <= k < N (diagonal skew).
        for (int i = 0; i < N; i++) begin
            a_edge_nxt[i] = '0;
            b_edge_nxt[i] = '0;
            if (state_nxt == ST_STREAM && step_nxt >= STEP_W'(i) &&
                (step_nxt - STEP_W'(i)) < STEP_W'(N)) begin
                a_edge_nxt[i] = a_mem[i][IDX_W'(step_nxt - STEP_W'(i))];
                b_edge_nxt[i] = b_mem[IDX_W'(step_nxt - STEP_W'(i))][i];
            end
        end
    end

    assign A0 = a_edge[0];
    assign A1 = a_edge[1];
    assign A2 = a_edge[2];
    assign A3 = a_edge[3];
    assign A4 = a_edge[4];
    assign A5 = a_edge[5];
    assign A6 = a_edge[6];
    assign A7 = a_edge[7];
    assign B0 = b_edge[0];
    assign B1 = b_edge[1];
    assign B2 = b_edge[2];
    assign B3 = b_edge[3];
    assign B4 = b_edge[4];
    assign B5 = b_edge[5];
    assign B6 = b_edge[6];
    assign B7 = b_edge[7];

endmodule

// File: tb/tb_sa_feeder.sv
// tb_sa_feeder: self-checking bench for sa_feeder. A behavioural 8x8
// systolic array sits on the DUT edge outputs; its results are compared
// against a plain matrix product, and edge wavefronts are compared against
// the skew rule computed from the bench's own copy of the matrices.
module tb_sa_feeder;

    localparam int unsigned N = 8;
    localparam int unsigned W = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, wr_sel, start;
    logic [2:0]  wr_row, wr_col;
    logic [7:0]  wr_data;
    logic        busy, done, sa_clr;
    logic [7:0]  A0, A1, A2, A3, A4, A5, A6, A7;
    logic [7:0]  B0, B1, B2, B3, B4, B5, B6, B7;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    logic [7:0]  ra [N][N];
    logic [7:0]  rb [N][N];

    logic [7:0]  dut_a [N];
    logic [7:0]  dut_b [N];
    logic [7:0]  pa [N][N];
    logic [7:0]  pb [N][N];
    logic [15:0] pc [N][N];
    logic [7:0]  a_in [N][N];
    logic [7:0]  b_in [N][N];

    sa_feeder #(.N(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row), .wr_col(wr_col),
        .wr_data(wr_data), .start(start),
        .busy(busy), .done(done), .sa_clr(sa_clr),
        .A0(A0), .A1(A1), .A2(A2), .A3(A3), .A4(A4), .A5(A5), .A6(A6), .A7(A7),
        .B0(B0), .B1(B1), .B2(B2), .B3(B3), .B4(B4), .B5(B5), .B6(B6), .B7(B7)
    );

    always #5 clk = ~clk;

    assign dut_a[0] = A0; assign dut_a[1] = A1; assign dut_a[2] = A2; assign dut_a[3] = A3;
    assign dut_a[4] = A4; assign dut_a[5] = A5; assign dut_a[6] = A6; assign dut_a[7] = A7;
    assign dut_b[0] = B0; assign dut_b[1] = B1; assign dut_b[2] = B2; assign dut_b[3] = B3;
    assign dut_b[4] = B4; assign dut_b[5] = B5; assign dut_b[6] = B6; assign dut_b[7] = B7;

    // Array model: operands enter from west/north, hop one PE per cycle.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_in[i][0] = dut_a[i];
            b_in[0][i] = dut_b[i];
            for (int j = 1; j < N; j++) begin
                a_in[i][j] = pa[i][j-1];
                b_in[j][i] = pb[j-1][i];
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (rst || sa_clr) begin
                    pa[i][j] <= '0;
                    pb[i][j] <= '0;
                    pc[i][j] <= '0;
                end else begin
                    pa[i][j] <= a_in[i][j];
                    pb[i][j] <= b_in[i][j];
                    pc[i][j] <= pc[i][j] + 16'(a_in[i][j]) * 16'(b_in[i][j]);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] obs_edges();
        logic [127:0] v;
        for (int i = 0; i < N; i++) begin
            v[i*8 +: 8]      = dut_a[i];
            v[64 + i*8 +: 8] = dut_b[i];
        end
        return v;
    endfunction

    // Expected edges at stream step t (t < 0 means all lanes idle).
    function automatic logic [127:0] exp_edges(input int t);
        logic [127:0] v = '0;
        for (int i = 0; i < N; i++) begin
            if (t >= i && t - i < N) begin
                v[i*8 +: 8]      = ra[i][t-i];
                v[64 + i*8 +: 8] = rb[t-i][i];
            end
        end
        return v;
    endfunction

    task automatic check_c(input string tag);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                int unsigned sum = 0;
                for (int k = 0; k < N; k++) sum += int'(ra[i][k]) * int'(rb[k][j]);
                chk($sformatf("%s C%0d%0d", tag, i, j), 128'(pc[i][j]), 128'(sum % 65536));
            end
        end
    endtask

    task automatic write_all();
        for (int s = 0; s < 2; s++) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    wr_en   = 1'b1;
                    wr_sel  = 1'(s);
                    wr_row  = 3'(r);
                    wr_col  = 3'(c);
                    wr_data = (s == 0) ? ra[r][c] : rb[r][c];
                    @(posedge clk); #1;
                end
            end
        end
        wr_en = 1'b0;
    endtask

    // One multiply from IDLE; returns in cycle 26 (or after a mid-run reset).
    task automatic run(input string tag, input int inject_cyc, input int reset_cyc,
                       input bit wr_at_start);
        int d0 = done_cnt;
        int t;
        start = 1'b1;
        if (wr_at_start) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_row = 3'd0; wr_col = 3'd0;
            wr_data = 8'($urandom);
            ra[0][0] = wr_data;
        end
        @(posedge clk); #1;
        for (int cyc = 1; cyc <= 26; cyc++) begin
            if (cyc > 1) begin
                @(posedge clk); #1;
            end
            start = 1'b0;
            wr_en = 1'b0;
            t = (cyc >= 2 && cyc <= 16) ? cyc - 2 : -1;
            chk($sformatf("%s edges c%0d", tag, cyc), obs_edges(), exp_edges(t));
            chk($sformatf("%s ctrl c%0d", tag, cyc), 128'({busy, done, sa_clr}),
                128'({cyc <= 25, cyc == 25, cyc == 1}));
            if (cyc == 25) check_c(tag);
            if (cyc == reset_cyc) begin
                rst = 1'b1;
                #1;
                chk({tag, " rst edges"}, obs_edges(), 128'(0));
                chk({tag, " rst ctrl"}, 128'({busy, done, sa_clr}), 128'(0));
                @(posedge clk); #1;
                rst = 1'b0;
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++) begin
                        ra[r][c] = '0;
                        rb[r][c] = '0;
                    end
                return;
            end
            if (cyc == inject_cyc) begin
                start   = 1'b1;
                wr_en   = 1'b1;
                wr_sel  = 1'($urandom);
                wr_row  = 3'($urandom_range(7, 0));
                wr_col  = 3'($urandom_range(7, 0));
                wr_data = 8'($urandom);
            end
        end
        chk({tag, " done count"}, 128'(done_cnt - d0), 128'(1));
    endtask

    task automatic set_identity();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ra[r][c] = (r == c) ? 8'd1 : 8'd0;
                rb[r][c] = 8'(8 * r + c);
            end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_col = '0;
        wr_data = '0; start = 1'b0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ra[r][c] = '0;
                rb[r][c] = '0;
            end
        repeat (2) @(posedge clk);
        #1;
        chk("reset edges", obs_edges(), 128'(0));
        chk("reset ctrl", 128'({busy, done, sa_clr}), 128'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Identity: C = B.
        set_identity();
        write_all();
        run("ident", -1, -1, 1'b0);
        chk("ident C25", 128'(pc[2][5]), 128'(21));
        chk("ident C77", 128'(pc[7][7]), 128'(63));

        // Skew waveform with B = 0.
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ra[r][c] = 8'(16 * r + c);
                rb[r][c] = '0;
            end
        write_all();
        run("skew", -1, -1, 1'b0);

        // Overflow: every C wraps to 8*65025 mod 65536.
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ra[r][c] = 8'hFF;
                rb[r][c] = 8'hFF;
            end
        write_all();
        run("ovf", -1, -1, 1'b0);
        chk("ovf C00", 128'(pc[0][0]), 128'(61448));
        chk("ovf C73", 128'(pc[7][3]), 128'(61448));

        // Random matrices, start/write pulsed mid-stream, then back-to-back reruns.
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ra[r][c] = 8'($urandom);
                rb[r][c] = 8'($urandom);
            end
        write_all();
        run("guard", 9, -1, 1'b0);
        run("b2b", -1, -1, 1'b0);
        run("wr_start", -1, -1, 1'b1);

        // Reset at t = 5, then no done and storage cleared.
        begin
            int d0;
            run("rst_mid", -1, 7, 1'b0);
            d0 = done_cnt;
            repeat (30) @(posedge clk);
            #1;
            chk("rst no done", 128'(done_cnt - d0), 128'(0));
            chk("rst idle", 128'(busy), 128'(0));
        end
        run("zeroed", -1, -1, 1'b0);
        set_identity();
        write_all();
        run("ident2", -1, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sa_feeder.md
# sa_feeder

Input sequencer for the 8x8 systolic matrix multiplier. It holds one A matrix and one B matrix (N x N, WIDTH-bit unsigned) in internal registers, loaded through a simple write port. On `start` it clears the array accumulators, drives the diagonally skewed A-row and B-column wavefronts onto the array's west and north edges, and zero-flushes until every product has reached its accumulator. It then pulses `done`, which tells the consumer that all C outputs are final.

## Interface
- N, 8, matrix dimension. The port list is fixed at 8 lanes, so N must equal 8. Counters are sized from N.
- WIDTH, 8, element width in bits.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- wr_en  in  1  write strobe for matrix storage.
- wr_sel  in  1  0 = write A, 1 = write B.
- wr_row  in  $clog2(N)  row index of the element.
- wr_col  in  $clog2(N)  column index of the element.
- wr_data  in  WIDTH  element value.
- start  in  1  begin one multiply, sampled in IDLE only.
- busy  out  1  high from CLEAR through DONE.
- done  out  1  one-cycle pulse: array results are final.
- sa_clr  out  1  accumulator clear; the top level ORs it into the array reset.
- A0..A7  out  WIDTH each  west-edge row inputs; A_i feeds array row i.
- B0..B7  out  WIDTH each  north-edge column inputs; B_j feeds array column j.

## Operation
- Storage: two N x N register banks, 2*N*N*WIDTH flops.
  - In IDLE, `wr_en` writes `wr_data` to A[wr_row][wr_col] or B[wr_row][wr_col] on the clock edge.
  - Writes in any other state are ignored and storage is unchanged.
- States: IDLE -> CLEAR -> STREAM -> DRAIN -> DONE -> IDLE.
  - IDLE: edge outputs 0, `busy` = 0. `start` = 1 moves to CLEAR.
  - CLEAR, 1 cycle: `sa_clr` = 1, edge outputs 0.
  - STREAM, 2N-1 cycles, with t = 0..2N-2 from a step counter: A_i = A[i][t-i] when 0 <= t-i <= N-1, else 0; B_j = B[t-j][j] when 0 <= t-j <= N-1, else 0.
  - DRAIN, N cycles: edge outputs 0, which flushes the pipeline. The last product A[N-1][N-1]*B[N-1][N-1] reaches PE(N-1,N-1) at t = 3N-3 and is accumulated.
  - DONE, 1 cycle: `done` = 1, then return to IDLE.
- Array model: each PE registers its a/b passthrough with 1-cycle latency and accumulates c on the same edge. C wraps modulo 2^(2*WIDTH); there is no saturation.
- `start` outside IDLE is ignored, with no queueing.
- `start` and `wr_en` in the same IDLE cycle: the write completes, and the stream uses the newly written value.
- Storage persists after a run. A second `start` recomputes from the same matrices.
- All outputs are registered.

## Timing
- Reset values: A0..A7 = 0, B0..B7 = 0, `busy` = 0, `done` = 0, `sa_clr` = 0, state = IDLE, all storage = 0.
- Reset asserted mid-run: immediate return to IDLE with every output and all storage at 0. No `done` is produced.
- Cycle numbering: `start` sampled high at edge 0. Then:
  - cycle 1: CLEAR (`sa_clr` = 1, `busy` = 1).
  - cycles 2..16: STREAM (t = 0..14).
  - cycles 17..24: DRAIN.
  - cycle 25: DONE (`done` = 1).
  - cycle 26: IDLE (`busy` = 0).
- Start-to-done latency is 3N+1 = 25 cycles. The next `start` is accepted in cycle 26.
- C outputs are final and stable from the `done` cycle until the next CLEAR.

## Test plan
- Identity: A = I, B[r][c] = 8r+c -> at `done`, every Cij equals 8i+j; `done` is high exactly 25 cycles after `start`.
- Skew waveform: A[i][k] = 16i+k, B = 0 -> A3 = 0x30 at t=3, 0x37 at t=10, and 0 at t=2 and t=11; every B_j = 0 throughout.
- Overflow: all A and B elements = 255 -> every Cij = 61448 (8*65025 mod 65536).
- Busy guards: `start` and `wr_en` pulsed during STREAM -> no restart and storage unchanged; a rerun gives identical C values, and `done` occurs once.
- Reset mid-STREAM (t=5) -> all outputs go to 0 in the same cycle, state is IDLE, no `done`; after reload and a new `start`, the identity test passes.
- Back-to-back: a second `start` in cycle 26 without new writes -> identical C, `done` at cycle 51.
